// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } if_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. A bubble wins over load; hold keeps the contents.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        load,
  input  logic        bubble,
  input  logic        hold,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);

  // Register update: reset/bubble to NOP with zeroed PCs, otherwise load or keep.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      instruction  <= NOP_INSTR;
      pc_out       <= '0;
      pc_plus4_out <= '0;
      valid_out    <= 1'b0;
    end else if (bubble) begin
      instruction  <= NOP_INSTR;
      pc_out       <= '0;
      pc_plus4_out <= '0;
      valid_out    <= 1'b0;
    end else if (load && !hold) begin
      instruction  <= instr_in;
      pc_out       <= pc_in;
      pc_plus4_out <= pc_in + 32'd4;   // wraps modulo 2^32
      valid_out    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, stall hold buffer and branch drain.
//
//   state | meaning
//   FETCH | request at pc; accept the word when busywait is low
//   HOLD  | word buffered while stalled; no memory request
//   DRAIN | wait out an access abandoned by a branch, discard its data
module if_stage #(
  parameter logic [31:0] RESET_PC  = if_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_readdata,
  input  logic        imem_busywait,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        valid_out
);

  import if_pkg::if_state_t;
  import if_pkg::FETCH;
  import if_pkg::HOLD;
  import if_pkg::DRAIN;

  if_state_t   state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] hold_word, hold_nxt;
  logic [31:0] drain_addr, drain_nxt;
  logic        ifid_load, ifid_bubble, ifid_hold;
  logic [31:0] ifid_src;

  // State, PC, hold buffer and abandoned-address registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      hold_word  <= '0;
      drain_addr <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      hold_word  <= hold_nxt;
      drain_addr <= drain_nxt;
    end
  end

  // Next-state and IF/ID control; a branch overrides stall in every state.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    hold_nxt    = hold_word;
    drain_nxt   = drain_addr;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_src    = imem_readdata;

    if (branch_taken) begin
      pc_nxt      = {branch_target[31:2], 2'b00};
      ifid_bubble = 1'b1;
      hold_nxt    = '0;
      // An outstanding access (FETCH or DRAIN with busywait high) must be
      // waited out; the abandoned address is the one first issued.
      if (state != HOLD && imem_busywait) begin
        state_nxt = DRAIN;
        if (state == FETCH) drain_nxt = pc;
      end else begin
        state_nxt = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (!imem_busywait) begin
            if (!stall) begin
              ifid_load = 1'b1;
              pc_nxt    = pc + 32'd4;
            end else begin
              hold_nxt  = imem_readdata;
              state_nxt = HOLD;
            end
          end else if (!stall) begin
            ifid_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_load = 1'b1;
            ifid_src  = hold_word;
            pc_nxt    = pc + 32'd4;
            hold_nxt  = '0;
            state_nxt = FETCH;
          end
        end
        DRAIN: begin
          if (!imem_busywait) state_nxt = FETCH;
          if (!stall) ifid_bubble = 1'b1;
        end
        default: state_nxt = FETCH;
      endcase
    end

    ifid_hold = !ifid_load && !ifid_bubble;
  end

  // Memory request: silent in reset and HOLD; DRAIN keeps the abandoned address.
  always_comb begin
    imem_read = RESET_N && (state != HOLD);
    imem_addr = (state == DRAIN) ? drain_addr : pc;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .load         (ifid_load),
    .bubble       (ifid_bubble),
    .hold         (ifid_hold),
    .instr_in     (ifid_src),
    .pc_in        (pc),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .valid_out    (valid_out)
  );

endmodule
